mux4_rr_arbiter: RTL

//   Upstream control stage for the 4:1 2-bit data mux (mux4_1).

---
 rtl/mux4_rr_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four sources feeding a one-entry valid/ready output register.
// Drives the mux select code for the chosen channel.
module mux4_rr_arbiter #(
  parameter int         DW       = 2,
  parameter logic [1:0] PTR_INIT = 2'd3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  output logic [3:0]    grant,
  output logic [1:0]    sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_ch
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr;
  logic [1:0]    win;
  logic [1:0]    idx;
  logic          found;
  logic          accept_slot;
  logic          take;
  logic [DW-1:0] win_data;

  // Search starts one past the last winner so the previous grantee has lowest priority.
  always_comb begin
    win   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign accept_slot = (state == EMPTY) || out_ready;
  // rst_n gating keeps grant low while the async reset is held.
  assign take        = rst_n && accept_slot && found;
  assign grant       = take ? (4'b0001 << win) : 4'b0000;
  assign sel         = take ? (2'd3 - win) : (2'd3 - ptr);
  assign out_valid   = (state == FULL);

  always_comb begin
    case (win)
      2'd0:    win_data = d0;
      2'd1:    win_data = d1;
      2'd2:    win_data = d2;
      default: win_data = d3;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (take)             state_nxt = FULL;
    else if (accept_slot) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= PTR_INIT;
      out_data <= '0;
      out_ch   <= 2'd0;
    end else if (take) begin
      ptr      <= win;
      out_data <= win_data;
      out_ch   <= win;
    end
  end

endmodule
